// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: bus widths, ALU op/select codes and divider states.
package ex_pkg;
   localparam int unsigned XLEN       = 32;
   localparam int unsigned DIV_STEPS  = XLEN;
   localparam int unsigned ALU_OP_W   = 8;
   localparam int unsigned ALU_SEL_W  = 3;
   localparam int unsigned REG_ADDR_W = 5;

   localparam logic                  WRITE_ENABLE  = 1'b1;
   localparam logic                  WRITE_DISABLE = 1'b0;
   localparam logic [XLEN-1:0]       ZERO_WORD     = '0;
   localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR  = '0;

   localparam logic [ALU_OP_W-1:0] EXE_NOP_OP    = 8'h00;
   localparam logic [ALU_OP_W-1:0] EXE_AND_OP    = 8'h01;
   localparam logic [ALU_OP_W-1:0] EXE_OR_OP     = 8'h02;
   localparam logic [ALU_OP_W-1:0] EXE_XOR_OP    = 8'h03;
   localparam logic [ALU_OP_W-1:0] EXE_SLL_OP    = 8'h04;
   localparam logic [ALU_OP_W-1:0] EXE_SRL_OP    = 8'h05;
   localparam logic [ALU_OP_W-1:0] EXE_SRA_OP    = 8'h06;
   localparam logic [ALU_OP_W-1:0] EXE_ADD_OP    = 8'h07;
   localparam logic [ALU_OP_W-1:0] EXE_SUB_OP    = 8'h08;
   localparam logic [ALU_OP_W-1:0] EXE_SLT_OP    = 8'h09;
   localparam logic [ALU_OP_W-1:0] EXE_SLTU_OP   = 8'h0a;
   localparam logic [ALU_OP_W-1:0] EXE_JAL_OP    = 8'h0b;
   localparam logic [ALU_OP_W-1:0] EXE_JALR_OP   = 8'h0c;
   localparam logic [ALU_OP_W-1:0] EXE_LB_OP     = 8'h10;
   localparam logic [ALU_OP_W-1:0] EXE_LH_OP     = 8'h11;
   localparam logic [ALU_OP_W-1:0] EXE_LW_OP     = 8'h12;
   localparam logic [ALU_OP_W-1:0] EXE_LBU_OP    = 8'h13;
   localparam logic [ALU_OP_W-1:0] EXE_LHU_OP    = 8'h14;
   localparam logic [ALU_OP_W-1:0] EXE_SB_OP     = 8'h18;
   localparam logic [ALU_OP_W-1:0] EXE_SH_OP     = 8'h19;
   localparam logic [ALU_OP_W-1:0] EXE_SW_OP     = 8'h1a;
   localparam logic [ALU_OP_W-1:0] EXE_MUL_OP    = 8'h20;
   localparam logic [ALU_OP_W-1:0] EXE_MULH_OP   = 8'h21;
   localparam logic [ALU_OP_W-1:0] EXE_MULHSU_OP = 8'h22;
   localparam logic [ALU_OP_W-1:0] EXE_MULHU_OP  = 8'h23;
   localparam logic [ALU_OP_W-1:0] EXE_DIV_OP    = 8'h24;
   localparam logic [ALU_OP_W-1:0] EXE_DIVU_OP   = 8'h25;
   localparam logic [ALU_OP_W-1:0] EXE_REM_OP    = 8'h26;
   localparam logic [ALU_OP_W-1:0] EXE_REMU_OP   = 8'h27;

   localparam logic [ALU_SEL_W-1:0] EXE_RES_NOP     = 3'd0;
   localparam logic [ALU_SEL_W-1:0] EXE_RES_LOGIC   = 3'd1;
   localparam logic [ALU_SEL_W-1:0] EXE_RES_SHIFT   = 3'd2;
   localparam logic [ALU_SEL_W-1:0] EXE_RES_ARITH   = 3'd3;
   localparam logic [ALU_SEL_W-1:0] EXE_RES_COMPARE = 3'd4;
   localparam logic [ALU_SEL_W-1:0] EXE_RES_JUMP    = 3'd5;
   localparam logic [ALU_SEL_W-1:0] EXE_RES_MULDIV  = 3'd6;

   typedef enum logic [1:0] {DivIdle, DivBusy, DivDone} div_state_e;

   function automatic logic is_div_op(input logic [ALU_OP_W-1:0] op);
      return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP) ||
             (op == EXE_REM_OP) || (op == EXE_REMU_OP);
   endfunction
endpackage

// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU; operands are held stable by the
// pipeline for the whole operation, so the sign fix-up is applied on the fly in DONE.
module ex_div_unit
   import ex_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            is_signed,
   input  logic            is_rem,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] result,
   output logic            busy,
   output logic            done
);
   div_state_e      state_q;
   logic [XLEN-1:0] rem_q, divisor_q, quot_q;
   logic [5:0]      count_q;
   logic            neg_q, neg_r;
   logic [XLEN-1:0] abs_a, abs_b;
   logic [XLEN:0]   trial;

   assign abs_a = (is_signed && dividend[XLEN-1]) ? (ZERO_WORD - dividend) : dividend;
   assign abs_b = (is_signed && divisor[XLEN-1]) ? (ZERO_WORD - divisor) : divisor;
   // Partial remainder shifted left by one with the next dividend bit, minus the divisor.
   assign trial = {rem_q, quot_q[XLEN-1]} - {1'b0, divisor_q};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= DivIdle;
         rem_q     <= '0;
         divisor_q <= '0;
         quot_q    <= '0;
         count_q   <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
      end else begin
         unique case (state_q)
            DivIdle: begin
               if (start) begin
                  if (divisor == ZERO_WORD) begin
                     quot_q  <= '1;
                     rem_q   <= dividend;
                     neg_q   <= 1'b0;
                     neg_r   <= 1'b0;
                     state_q <= DivDone;
                  end else begin
                     quot_q    <= abs_a;
                     rem_q     <= '0;
                     divisor_q <= abs_b;
                     count_q   <= '0;
                     neg_q     <= is_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
                     neg_r     <= is_signed && dividend[XLEN-1];
                     state_q   <= DivBusy;
                  end
               end
            end
            DivBusy: begin
               if (!trial[XLEN]) begin
                  rem_q  <= trial[XLEN-1:0];
                  quot_q <= {quot_q[XLEN-2:0], 1'b1};
               end else begin
                  rem_q  <= {rem_q[XLEN-2:0], quot_q[XLEN-1]};
                  quot_q <= {quot_q[XLEN-2:0], 1'b0};
               end
               count_q <= count_q + 6'd1;
               if (count_q == 6'(DIV_STEPS - 1)) state_q <= DivDone;
            end
            DivDone: state_q <= DivIdle;
            default: state_q <= DivIdle;
         endcase
      end
   end

   always_comb begin
      if (is_rem) result = neg_r ? (ZERO_WORD - rem_q) : rem_q;
      else        result = neg_q ? (ZERO_WORD - quot_q) : quot_q;
   end

   assign busy = (state_q == DivBusy);
   assign done = (state_q == DivDone);
endmodule

// File: rtl/ex.sv
// Execute stage of the RV32IM pipeline: single-cycle ALU/shift/compare/multiply/link/address,
// with an iterative divider that holds the pipeline via stallreq_o while it runs.
module ex
   import ex_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ALU_OP_W-1:0]   aluop_i,
   input  logic [ALU_SEL_W-1:0]  alusel_i,
   input  logic [XLEN-1:0]       reg1_i,
   input  logic [XLEN-1:0]       reg2_i,
   input  logic [XLEN-1:0]       imm_i,
   input  logic                  wreg_i,
   input  logic [REG_ADDR_W-1:0] wd_i,
   input  logic [XLEN-1:0]       jb_link_addr_i,
   output logic                  wreg_o,
   output logic [REG_ADDR_W-1:0] wd_o,
   output logic [XLEN-1:0]       wdata_o,
   output logic [ALU_OP_W-1:0]   aluop_o,
   output logic [XLEN-1:0]       mem_addr_o,
   output logic [XLEN-1:0]       reg2_o,
   output logic                  stallreq_o
);
   logic [XLEN-1:0]          logic_res, shift_res, arith_res, cmp_res, mul_res, div_res;
   logic signed [2*XLEN-1:0] mul_a, mul_b, mul_prod;
   logic                     a_signed, b_signed;
   logic                     div_op, div_signed, div_rem, div_busy, div_done, div_stall;
   logic [4:0]               shamt;

   assign shamt      = reg2_i[4:0];
   assign div_op     = is_div_op(aluop_i);
   assign div_signed = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_REM_OP);
   assign div_rem    = (aluop_i == EXE_REM_OP) || (aluop_i == EXE_REMU_OP);
   // Held from divide decode through the last iteration; drops in the result cycle.
   assign div_stall  = !rst && !div_done && (div_op || div_busy);

   ex_div_unit u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_op),
      .is_signed (div_signed),
      .is_rem    (div_rem),
      .dividend  (reg1_i),
      .divisor   (reg2_i),
      .result    (div_res),
      .busy      (div_busy),
      .done      (div_done)
   );

   always_comb begin
      logic_res = ZERO_WORD;
      shift_res = ZERO_WORD;
      arith_res = ZERO_WORD;
      cmp_res   = ZERO_WORD;
      case (aluop_i)
         EXE_AND_OP:  logic_res = reg1_i & reg2_i;
         EXE_OR_OP:   logic_res = reg1_i | reg2_i;
         EXE_XOR_OP:  logic_res = reg1_i ^ reg2_i;
         EXE_SLL_OP:  shift_res = reg1_i << shamt;
         EXE_SRL_OP:  shift_res = reg1_i >> shamt;
         EXE_SRA_OP:  shift_res = $signed(reg1_i) >>> shamt;
         EXE_ADD_OP:  arith_res = reg1_i + reg2_i;
         EXE_SUB_OP:  arith_res = reg1_i - reg2_i;
         EXE_SLT_OP:  cmp_res = {{(XLEN-1){1'b0}}, $signed(reg1_i) < $signed(reg2_i)};
         EXE_SLTU_OP: cmp_res = {{(XLEN-1){1'b0}}, reg1_i < reg2_i};
         default: ;
      endcase
   end

   // 33x33 signed product realised as a 64-bit product of sign- or zero-extended operands.
   always_comb begin
      a_signed = (aluop_i != EXE_MULHU_OP);
      b_signed = (aluop_i == EXE_MUL_OP) || (aluop_i == EXE_MULH_OP);
      mul_a    = {{XLEN{a_signed && reg1_i[XLEN-1]}}, reg1_i};
      mul_b    = {{XLEN{b_signed && reg2_i[XLEN-1]}}, reg2_i};
      mul_prod = mul_a * mul_b;
      mul_res  = (aluop_i == EXE_MUL_OP) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
   end

   always_comb begin
      wreg_o     = WRITE_DISABLE;
      wd_o       = NOP_REG_ADDR;
      wdata_o    = ZERO_WORD;
      aluop_o    = EXE_NOP_OP;
      mem_addr_o = ZERO_WORD;
      reg2_o     = ZERO_WORD;
      stallreq_o = 1'b0;
      if (!rst) begin
         aluop_o    = aluop_i;
         mem_addr_o = reg1_i + imm_i;
         reg2_o     = reg2_i;
         stallreq_o = div_stall;
         wreg_o     = div_stall ? WRITE_DISABLE : wreg_i;
         wd_o       = div_stall ? NOP_REG_ADDR : wd_i;
         case (alusel_i)
            EXE_RES_LOGIC:   wdata_o = logic_res;
            EXE_RES_SHIFT:   wdata_o = shift_res;
            EXE_RES_ARITH:   wdata_o = arith_res;
            EXE_RES_COMPARE: wdata_o = cmp_res;
            EXE_RES_JUMP:    wdata_o = jb_link_addr_i;
            EXE_RES_MULDIV:  wdata_o = div_op ? div_res : mul_res;
            default:         wdata_o = ZERO_WORD;
         endcase
      end
   end
endmodule

// File: tb/tb_ex.sv
// Self-checking bench for the execute stage: directed vector table, divide corner sequences
// and randomized operations compared against an arithmetic reference model.
module tb_ex;
   import ex_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [ALU_OP_W-1:0]   aluop_i;
   logic [ALU_SEL_W-1:0]  alusel_i;
   logic [XLEN-1:0]       reg1_i, reg2_i, imm_i, jb_link_addr_i;
   logic                  wreg_i;
   logic [REG_ADDR_W-1:0] wd_i;
   logic                  wreg_o;
   logic [REG_ADDR_W-1:0] wd_o;
   logic [XLEN-1:0]       wdata_o, mem_addr_o, reg2_o;
   logic [ALU_OP_W-1:0]   aluop_o;
   logic                  stallreq_o;

   int errors = 0;
   int checks = 0;

   ex dut (
      .clk            (clk),
      .rst            (rst),
      .aluop_i        (aluop_i),
      .alusel_i       (alusel_i),
      .reg1_i         (reg1_i),
      .reg2_i         (reg2_i),
      .imm_i          (imm_i),
      .wreg_i         (wreg_i),
      .wd_i           (wd_i),
      .jb_link_addr_i (jb_link_addr_i),
      .wreg_o         (wreg_o),
      .wd_o           (wd_o),
      .wdata_o        (wdata_o),
      .aluop_o        (aluop_o),
      .mem_addr_o     (mem_addr_o),
      .reg2_o         (reg2_o),
      .stallreq_o     (stallreq_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ALU_OP_W-1:0]  op;
      logic [ALU_SEL_W-1:0] sel;
      logic [31:0]          a;
      logic [31:0]          b;
      logic [31:0]          imm;
      logic [31:0]          link;
      logic [31:0]          exp;
   } vec_t;

   typedef struct {
      logic [ALU_OP_W-1:0]  op;
      logic [ALU_SEL_W-1:0] sel;
   } opsel_t;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
      end
   endtask

   // Reference results from the ISA's arithmetic definitions using 64-bit integers.
   function automatic logic [31:0] model(input logic [ALU_OP_W-1:0] op,
                                         input logic [ALU_SEL_W-1:0] sel,
                                         input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] link);
      longint          sa, sb, p;
      longint unsigned ua, ub, pu;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      if (sel == EXE_RES_NOP) return 32'h0;
      if (sel == EXE_RES_JUMP) return link;
      case (op)
         EXE_ADD_OP:    return 32'(ua + ub);
         EXE_SUB_OP:    return 32'(ua - ub);
         EXE_AND_OP:    return a & b;
         EXE_OR_OP:     return a | b;
         EXE_XOR_OP:    return a ^ b;
         EXE_SLL_OP:    return 32'(ua << b[4:0]);
         EXE_SRL_OP:    return 32'(ua >> b[4:0]);
         EXE_SRA_OP:    return 32'(sa >>> b[4:0]);
         EXE_SLT_OP:    return (sa < sb) ? 32'd1 : 32'd0;
         EXE_SLTU_OP:   return (ua < ub) ? 32'd1 : 32'd0;
         EXE_MUL_OP:    return 32'(sa * sb);
         EXE_MULH_OP:   begin p = sa * sb; return p[63:32]; end
         EXE_MULHSU_OP: begin p = sa * longint'(ub); return p[63:32]; end
         EXE_MULHU_OP:  begin pu = ua * ub; return pu[63:32]; end
         EXE_DIV_OP:    return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
         EXE_DIVU_OP:   return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
         EXE_REM_OP:    return (b == 0) ? a : 32'(sa % sb);
         EXE_REMU_OP:   return (b == 0) ? a : 32'(ua % ub);
         default:       return 32'h0;
      endcase
   endfunction

   // Called at posedge+1; returns at the next posedge+1 after the result cycle.
   task automatic do_op(input string name, input logic [ALU_OP_W-1:0] op,
                        input logic [ALU_SEL_W-1:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm, input logic [31:0] link,
                        input logic [4:0] wd);
      logic [31:0] exp;
      int          exp_stall, stalls;
      bit          div, bubble_ok;
      exp       = model(op, sel, a, b, link);
      div       = op inside {EXE_DIV_OP, EXE_DIVU_OP, EXE_REM_OP, EXE_REMU_OP};
      exp_stall = !div ? 0 : ((b == 0) ? 1 : DIV_STEPS + 1);
      aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b; imm_i = imm;
      jb_link_addr_i = link; wreg_i = 1'b1; wd_i = wd;
      stalls    = 0;
      bubble_ok = 1'b1;
      @(negedge clk);
      while (stallreq_o === 1'b1 && stalls < 40) begin
         if (wreg_o !== 1'b0 || wd_o !== 5'd0) bubble_ok = 1'b0;
         stalls++;
         @(negedge clk);
      end
      check({name, " stall cycles"}, stalls, exp_stall);
      check({name, " wdata"}, wdata_o, exp);
      check({name, " wreg"}, {31'b0, wreg_o}, 32'd1);
      check({name, " wd"}, {27'b0, wd_o}, {27'b0, wd});
      check({name, " mem_addr"}, mem_addr_o, a + imm);
      if (div) check({name, " bubble while stalled"}, {31'b0, bubble_ok}, 32'd1);
      @(posedge clk);
      #1;
   endtask

   vec_t   vecs[$];
   opsel_t ops[$];

   initial begin
      int          stalls;
      logic [31:0] ra, rb;
      opsel_t      os;

      vecs.push_back('{EXE_ADD_OP,    EXE_RES_ARITH,   32'h7FFF_FFFF, 32'h1, 32'h0, 32'h0, 32'h8000_0000});
      vecs.push_back('{EXE_SUB_OP,    EXE_RES_ARITH,   32'h0, 32'h1, 32'h4, 32'h0, 32'hFFFF_FFFF});
      vecs.push_back('{EXE_AND_OP,    EXE_RES_LOGIC,   32'hF0F0_1234, 32'hFF00_FF00, 32'h0, 32'h0, 32'hF000_1200});
      vecs.push_back('{EXE_OR_OP,     EXE_RES_LOGIC,   32'hF0F0_0000, 32'h0000_000F, 32'h0, 32'h0, 32'hF0F0_000F});
      vecs.push_back('{EXE_XOR_OP,    EXE_RES_LOGIC,   32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0, 32'h0, 32'hF0F0_0F0F});
      vecs.push_back('{EXE_SLL_OP,    EXE_RES_SHIFT,   32'h1, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h8000_0000});
      vecs.push_back('{EXE_SRL_OP,    EXE_RES_SHIFT,   32'h8000_0000, 32'h24, 32'h0, 32'h0, 32'h0800_0000});
      vecs.push_back('{EXE_SRA_OP,    EXE_RES_SHIFT,   32'h8000_0000, 32'h24, 32'h0, 32'h0, 32'hF800_0000});
      vecs.push_back('{EXE_SLT_OP,    EXE_RES_COMPARE, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 32'h1});
      vecs.push_back('{EXE_SLTU_OP,   EXE_RES_COMPARE, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 32'h0});
      vecs.push_back('{EXE_JAL_OP,    EXE_RES_JUMP,    32'h100, 32'h0, 32'h0, 32'h0000_2004, 32'h0000_2004});
      vecs.push_back('{EXE_MUL_OP,    EXE_RES_MULDIV,  32'h7, 32'hFFFF_FFFA, 32'h0, 32'h0, 32'hFFFF_FFD6});
      vecs.push_back('{EXE_MULH_OP,   EXE_RES_MULDIV,  32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0, 32'h4000_0000});
      vecs.push_back('{EXE_MULHSU_OP, EXE_RES_MULDIV,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFF});
      vecs.push_back('{EXE_MULHU_OP,  EXE_RES_MULDIV,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFE});
      vecs.push_back('{EXE_LW_OP,     EXE_RES_NOP,     32'h1000, 32'hCAFE, 32'hFFFF_FFFC, 32'h0, 32'h0});
      vecs.push_back('{EXE_DIV_OP,    EXE_RES_MULDIV,  32'hFFFF_FFF9, 32'h2, 32'h0, 32'h0, 32'hFFFF_FFFD});
      vecs.push_back('{EXE_REM_OP,    EXE_RES_MULDIV,  32'hFFFF_FFF9, 32'h2, 32'h0, 32'h0, 32'hFFFF_FFFF});
      vecs.push_back('{EXE_DIVU_OP,   EXE_RES_MULDIV,  32'd100, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF});
      vecs.push_back('{EXE_REMU_OP,   EXE_RES_MULDIV,  32'd100, 32'h0, 32'h0, 32'h0, 32'd100});
      vecs.push_back('{EXE_DIV_OP,    EXE_RES_MULDIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h8000_0000});
      vecs.push_back('{EXE_REM_OP,    EXE_RES_MULDIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0});

      // Reset with live inputs: every output must show its idle value.
      rst = 1'b1;
      aluop_i = EXE_DIV_OP; alusel_i = EXE_RES_MULDIV; reg1_i = 32'h55; reg2_i = 32'h3;
      imm_i = 32'h10; jb_link_addr_i = 32'h44; wreg_i = 1'b1; wd_i = 5'd7;
      @(negedge clk);
      check("reset stallreq", {31'b0, stallreq_o}, 32'd0);
      check("reset wreg", {31'b0, wreg_o}, 32'd0);
      check("reset wd", {27'b0, wd_o}, 32'd0);
      check("reset wdata", wdata_o, 32'd0);
      check("reset mem_addr", mem_addr_o, 32'd0);
      check("reset reg2", reg2_o, 32'd0);
      check("reset aluop", {24'b0, aluop_o}, {24'b0, EXE_NOP_OP});
      @(posedge clk);
      #1;
      rst = 1'b0;

      foreach (vecs[i]) begin
         check($sformatf("vec%0d model", i),
               model(vecs[i].op, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].link), vecs[i].exp);
         aluop_i = vecs[i].op;
         reg2_i  = vecs[i].b;
         #1;
         check($sformatf("vec%0d aluop pass", i), {24'b0, aluop_o}, {24'b0, vecs[i].op});
         check($sformatf("vec%0d reg2 pass", i), reg2_o, vecs[i].b);
         do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].sel, vecs[i].a, vecs[i].b,
               vecs[i].imm, vecs[i].link, 5'(i + 1));
      end

      // Reset during BUSY (count=10) aborts the divide immediately.
      aluop_i = EXE_DIVU_OP; alusel_i = EXE_RES_MULDIV; reg1_i = 32'h1234_5678;
      reg2_i = 32'h3; imm_i = 32'h0; wreg_i = 1'b1; wd_i = 5'd9;
      stalls = 0;
      repeat (11) begin
         @(negedge clk);
         if (stallreq_o === 1'b1) stalls++;
      end
      check("abort stalls before reset", stalls, 11);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("abort stallreq", {31'b0, stallreq_o}, 32'd0);
      check("abort wreg", {31'b0, wreg_o}, 32'd0);
      check("abort wd", {27'b0, wd_o}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      do_op("divu after abort", EXE_DIVU_OP, EXE_RES_MULDIV, 32'd10, 32'd3, 32'h0, 32'h0, 5'd9);

      ops.push_back('{EXE_ADD_OP, EXE_RES_ARITH});    ops.push_back('{EXE_SUB_OP, EXE_RES_ARITH});
      ops.push_back('{EXE_AND_OP, EXE_RES_LOGIC});    ops.push_back('{EXE_OR_OP, EXE_RES_LOGIC});
      ops.push_back('{EXE_XOR_OP, EXE_RES_LOGIC});    ops.push_back('{EXE_SLL_OP, EXE_RES_SHIFT});
      ops.push_back('{EXE_SRL_OP, EXE_RES_SHIFT});    ops.push_back('{EXE_SRA_OP, EXE_RES_SHIFT});
      ops.push_back('{EXE_SLT_OP, EXE_RES_COMPARE});  ops.push_back('{EXE_SLTU_OP, EXE_RES_COMPARE});
      ops.push_back('{EXE_JALR_OP, EXE_RES_JUMP});    ops.push_back('{EXE_SW_OP, EXE_RES_NOP});
      ops.push_back('{EXE_MUL_OP, EXE_RES_MULDIV});   ops.push_back('{EXE_MULH_OP, EXE_RES_MULDIV});
      ops.push_back('{EXE_MULHSU_OP, EXE_RES_MULDIV}); ops.push_back('{EXE_MULHU_OP, EXE_RES_MULDIV});
      ops.push_back('{EXE_DIV_OP, EXE_RES_MULDIV});   ops.push_back('{EXE_DIVU_OP, EXE_RES_MULDIV});
      ops.push_back('{EXE_REM_OP, EXE_RES_MULDIV});   ops.push_back('{EXE_REMU_OP, EXE_RES_MULDIV});

      for (int n = 0; n < 80; n++) begin
         os = ops[$urandom_range(ops.size() - 1)];
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(7))
            0: rb = 32'h0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(15));
            default: ;
         endcase
         do_op($sformatf("rand%0d op%02h a%08h b%08h", n, os.op, ra, rb), os.op, os.sel,
               ra, rb, $urandom, $urandom, 5'($urandom_range(31, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
